alu_seq_unit: RTL

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_core.sv | 46 ++++
 rtl/alu_seq_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, operand selects,
// branch conditions and the controller state type.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    localparam logic [1:0] SRCA_PC  = 2'b00;
    localparam logic [1:0] SRCA_SP  = 2'b01;
    localparam logic [1:0] SRCA_ACC = 2'b10;
    localparam logic [1:0] SRCA_MEM = 2'b11;

    localparam logic [1:0] SRCB_IMM  = 2'b00;
    localparam logic [1:0] SRCB_MEM  = 2'b01;
    localparam logic [1:0] SRCB_ONE  = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    localparam logic [1:0] COND_Z   = 2'b00;
    localparam logic [1:0] COND_NZ  = 2'b01;
    localparam logic [1:0] COND_NEG = 2'b10;
    localparam logic [1:0] COND_ALW = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU. Shifts here use the full shift amount;
// the sequencer only relies on this path for shamt == 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovfl
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [SHW-1:0]   shamt;

    // Result mux; overflow only meaningful for add/sub.
    always_comb begin
        sum   = a + b;
        dif   = a - b;
        shamt = b[SHW-1:0];
        y     = '0;
        ovfl  = 1'b0;
        case (op)
            OP_ADD: begin
                y    = sum;
                ovfl = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y    = dif;
                ovfl = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SLT:  y[0] = ($signed(a) < $signed(b));
            default: y = b;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle ops complete at the Start edge, shifts by a
// nonzero amount step one bit per cycle. Flags move only with ALUOut.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM_W = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       ALUOp,
    input  logic [1:0]       ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic             SIGNExt,
    input  logic [IMM_W-1:0] IROut,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] SP,
    input  logic [WIDTH-1:0] ACC,
    input  logic [WIDTH-1:0] Memout,
    input  logic             BranchCycle,
    input  logic [1:0]       BranchCond,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             ovfl,
    output logic             DOBRANCH
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] a_mux;
    logic [WIDTH-1:0] b_mux;
    logic [WIDTH-1:0] core_y;
    logic             core_ovfl;
    logic [WIDTH-1:0] a_r;      // captured A, doubles as the shift register
    logic [2:0]       op_r;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt_in;
    logic             is_shift;
    logic [WIDTH-1:0] shift1;
    logic             cond;

    // Operand selection and immediate extension.
    always_comb begin
        imm_ext = SIGNExt ? {{(WIDTH-IMM_W){IROut[IMM_W-1]}}, IROut}
                          : {{(WIDTH-IMM_W){1'b0}}, IROut};
        case (ALUSrcA)
            SRCA_PC:  a_mux = PC;
            SRCA_SP:  a_mux = SP;
            SRCA_ACC: a_mux = ACC;
            default:  a_mux = Memout;
        endcase
        case (ALUSrcB)
            SRCB_IMM: b_mux = imm_ext;
            SRCB_MEM: b_mux = Memout;
            SRCB_ONE: b_mux = {{(WIDTH-1){1'b0}}, 1'b1};
            default:  b_mux = '0;
        endcase
        shamt_in = b_mux[SHW-1:0];
        is_shift = (ALUOp == OP_SLL) || (ALUOp == OP_SRL);
        shift1   = (op_r == OP_SLL) ? {a_r[WIDTH-2:0], 1'b0} : {1'b0, a_r[WIDTH-1:1]};
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op   (ALUOp),
        .a    (a_mux),
        .b    (b_mux),
        .y    (core_y),
        .ovfl (core_ovfl)
    );

    // Controller: IDLE finishes simple ops in place, SHIFT counts down one bit per edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= ST_IDLE;
            ALUOut <= '0;
            Zero   <= 1'b1;
            ovfl   <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            cnt    <= '0;
            a_r    <= '0;
            op_r   <= OP_ADD;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        a_r  <= a_mux;
                        op_r <= ALUOp;
                        if (is_shift && (shamt_in != '0)) begin
                            state <= ST_SHIFT;
                            Busy  <= 1'b1;
                            cnt   <= shamt_in;
                        end else begin
                            ALUOut <= core_y;
                            Zero   <= (core_y == '0);
                            ovfl   <= core_ovfl;
                            Done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    a_r <= shift1;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        ALUOut <= shift1;
                        Zero   <= (shift1 == '0);
                        ovfl   <= 1'b0;
                        Done   <= 1'b1;
                        Busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Branch decision from the registered flags, suppressed while busy.
    always_comb begin
        case (BranchCond)
            COND_Z:   cond = Zero;
            COND_NZ:  cond = ~Zero;
            COND_NEG: cond = ALUOut[WIDTH-1];
            default:  cond = 1'b1;
        endcase
        DOBRANCH = BranchCycle & cond & ~Busy;
    end

endmodule
